shift_sequencer: RTL and testbench

- Multi-cycle, arbitrated ARM operand shifter.
- Shared between two requesters: port 0 is the data-processing operand2 path; port 1 is the load/store register-offset path.
- Implements full ARM LSL/LSR/ASR/ROR/RRX semantics, including shift-by-register amounts 0..255 and shifter carry-out, by shifting up to STEP bits per cycle.
- Sits between register-read and the ALU/address adder; one operation in flight at a time.

---
 rtl/shift_seq_pkg.sv | 42 ++++
 rtl/shift_sequencer_if.sv | 27 ++
 rtl/shift_step.sv | 48 ++++
 rtl/shift_sequencer.sv | 124 ++++++++++++
 tb/tb_shift_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the arbitrated ARM operand shifter.
// Holds the shift-type codes, FSM states and the effective-amount rules.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int unsigned AMT_LSL_MAX = 33;
    localparam int unsigned AMT_ASR_MAX = 32;

    // Number of single-bit positions the iterative shifter must walk through.
    // Immediate ROR #0 (RRX) is resolved by the caller before this is used.
    function automatic logic [5:0] calc_eff(input logic [7:0] amt, input shift_t sh,
                                            input logic imm);
        logic [5:0] eff;
        eff = '0;
        if (imm && amt == 8'd0) begin
            eff = (sh == SH_LSL) ? 6'd0 : 6'd32;
        end else begin
            case (sh)
                SH_LSL, SH_LSR: eff = (amt >= 8'(AMT_LSL_MAX)) ? 6'(AMT_LSL_MAX) : amt[5:0];
                SH_ASR:         eff = (amt >= 8'(AMT_ASR_MAX)) ? 6'(AMT_ASR_MAX) : amt[5:0];
                default: begin
                    if (amt[4:0] == 5'd0) eff = (amt != 8'd0) ? 6'd32 : 6'd0;
                    else                  eff = {1'b0, amt[4:0]};
                end
            endcase
        end
        return eff;
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle for the shared shifter: two requesters, one result port.
interface shift_sequencer_if;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data,  req1_data;
    logic [7:0]  req0_amt,   req1_amt;
    logic [1:0]  req0_type,  req1_type;
    logic        req0_imm,   req1_imm;
    logic        req0_cin,   req1_cin;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_data;
    logic        resp_carry;

    modport master (
        output req0_valid, req1_valid, req0_data, req1_data, req0_amt, req1_amt,
               req0_type, req1_type, req0_imm, req1_imm, req0_cin, req1_cin, resp_ready,
        input  req0_ready, req1_ready, resp_valid, resp_id, resp_data, resp_carry
    );

    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data, req0_amt, req1_amt,
               req0_type, req1_type, req0_imm, req1_imm, req0_cin, req1_cin, resp_ready,
        output req0_ready, req1_ready, resp_valid, resp_id, resp_data, resp_carry
    );
endinterface

// File: rtl/shift_step.sv
// One combinational shifter step of k bits (0..STEP) with ARM carry-out.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int unsigned STEP = 4,
    localparam int unsigned KW = $clog2(STEP + 1)
) (
    input  logic [31:0]   value,
    input  shift_t        shtype,
    input  logic [KW-1:0] k,
    output logic [31:0]   value_out,
    output logic          carry_out
);

    logic [5:0]         kk;
    logic [32:0]        lsl_w;
    logic [32:0]        lsr_w;
    logic signed [32:0] asr_w;

    // Extra guard bit on each side captures the last bit shifted out.
    always_comb begin
        kk        = 6'(k);
        lsl_w     = {1'b0, value} << kk;
        lsr_w     = {value, 1'b0} >> kk;
        asr_w     = $signed({value, 1'b0}) >>> kk;
        value_out = value;
        carry_out = 1'b0;
        case (shtype)
            SH_LSL: begin
                value_out = lsl_w[31:0];
                carry_out = lsl_w[32];
            end
            SH_LSR: begin
                value_out = lsr_w[32:1];
                carry_out = lsr_w[0];
            end
            SH_ASR: begin
                value_out = asr_w[32:1];
                carry_out = asr_w[0];
            end
            default: begin
                value_out = (value >> kk) | (value << (6'd32 - kk));
                carry_out = lsr_w[0];
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Arbitrated multi-cycle ARM operand shifter; walks up to STEP bits per cycle
// so large and register-specified amounts reuse one narrow shift stage.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned STEP = 4
) (
    input logic              clk,
    input logic              reset,
    shift_sequencer_if.slave bus
);

    localparam int unsigned KW = $clog2(STEP + 1);

    state_t        state_q;
    logic          last_grant_q;
    logic [31:0]   val_q;
    logic          carry_q;
    logic          id_q;
    shift_t        sh_q;
    logic [5:0]    remaining_q;
    logic          resp_valid_q;

    logic          idle, grant0, grant1;
    logic [31:0]   in_data;
    logic [7:0]    in_amt;
    shift_t        in_sh;
    logic          in_imm, in_cin;
    logic [5:0]    in_eff;
    logic [KW-1:0] k;
    logic [31:0]   step_val;
    logic          step_carry;

    // Round-robin: on contention the port that did not win last time goes.
    assign idle   = (state_q == ST_IDLE);
    assign grant0 = idle && bus.req0_valid && (!bus.req1_valid || last_grant_q);
    assign grant1 = idle && bus.req1_valid && (!bus.req0_valid || !last_grant_q);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    assign in_data = grant1 ? bus.req1_data : bus.req0_data;
    assign in_amt  = grant1 ? bus.req1_amt  : bus.req0_amt;
    assign in_sh   = grant1 ? shift_t'(bus.req1_type) : shift_t'(bus.req0_type);
    assign in_imm  = grant1 ? bus.req1_imm  : bus.req0_imm;
    assign in_cin  = grant1 ? bus.req1_cin  : bus.req0_cin;
    assign in_eff  = calc_eff(in_amt, in_sh, in_imm);

    always_comb begin
        if (remaining_q > 6'(STEP)) k = KW'(STEP);
        else                        k = remaining_q[KW-1:0];
    end

    shift_step #(
        .STEP(STEP)
    ) u_step (
        .value    (val_q),
        .shtype   (sh_q),
        .k        (k),
        .value_out(step_val),
        .carry_out(step_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            val_q        <= '0;
            carry_q      <= 1'b0;
            id_q         <= 1'b0;
            sh_q         <= SH_LSL;
            remaining_q  <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        id_q         <= grant1;
                        last_grant_q <= grant1;
                        sh_q         <= in_sh;
                        if (in_imm && in_amt == 8'd0 && in_sh == SH_ROR) begin
                            val_q        <= {in_cin, in_data[31:1]};
                            carry_q      <= in_data[0];
                            state_q      <= ST_DONE;
                            resp_valid_q <= 1'b1;
                        end else begin
                            val_q       <= in_data;
                            carry_q     <= in_cin;
                            remaining_q <= in_eff;
                            if (in_eff == 6'd0) begin
                                state_q      <= ST_DONE;
                                resp_valid_q <= 1'b1;
                            end else begin
                                state_q <= ST_SHIFT;
                            end
                        end
                    end
                end
                ST_SHIFT: begin
                    val_q       <= step_val;
                    carry_q     <= step_carry;
                    remaining_q <= remaining_q - 6'(k);
                    if (remaining_q == 6'(k)) begin
                        state_q      <= ST_DONE;
                        resp_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = val_q;
    assign bus.resp_carry = carry_q;
    assign bus.resp_id    = id_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed table, arbitration and reset
// sequences, then random operations against an arithmetic reference model.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int unsigned STEP = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    shift_sequencer_if bus ();

    shift_sequencer #(
        .STEP(STEP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] d;
        logic [7:0]  a;
        logic [1:0]  t;
        logic        im;
        logic        ci;
        logic [31:0] er;
        logic        ec;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: evaluate the ARM shift directly with 64-bit arithmetic.
    function automatic void ref_op(input logic [31:0] d, input logic [7:0] a,
                                   input logic [1:0] t, input logic im, input logic ci,
                                   output logic [31:0] r, output logic c, output int lat);
        logic [63:0] w;
        int n;
        int m;
        if (im && a == 8'd0) begin
            case (t)
                2'd0:       n = 0;
                2'd1, 2'd2: n = 32;
                default:    n = -1;
            endcase
        end else begin
            case (t)
                2'd0, 2'd1: n = (int'(a) > 33) ? 33 : int'(a);
                2'd2:       n = (int'(a) > 32) ? 32 : int'(a);
                default:    n = (a == 8'd0) ? 0 : (((int'(a) % 32) == 0) ? 32 : int'(a) % 32);
            endcase
        end
        if (n < 0) begin
            r   = {ci, d[31:1]};
            c   = d[0];
            lat = 1;
            return;
        end
        lat = 1 + (n + int'(STEP) - 1) / int'(STEP);
        r   = d;
        c   = ci;
        if (n == 0) return;
        case (t)
            2'd0: begin
                w = {32'b0, d} << n;
                r = w[31:0];
                c = w[32];
            end
            2'd1: begin
                w = {d, 32'b0} >> n;
                r = w[63:32];
                c = w[31];
            end
            2'd2: begin
                w = $signed({d, 32'b0}) >>> n;
                r = w[63:32];
                c = w[31];
            end
            default: begin
                m = n % 32;
                if (m == 0) begin
                    r = d;
                    c = d[31];
                end else begin
                    r = (d >> m) | (d << (32 - m));
                    c = d[m-1];
                end
            end
        endcase
    endfunction

    function automatic logic port_ready(input int p);
        return (p != 0) ? bus.req1_ready : bus.req0_ready;
    endfunction

    task automatic set_port(input int p, input logic v, input logic [31:0] d,
                            input logic [7:0] a, input logic [1:0] t, input logic im,
                            input logic ci);
        if (p != 0) begin
            bus.req1_valid = v; bus.req1_data = d; bus.req1_amt = a;
            bus.req1_type  = t; bus.req1_imm  = im; bus.req1_cin = ci;
        end else begin
            bus.req0_valid = v; bus.req0_data = d; bus.req0_amt = a;
            bus.req0_type  = t; bus.req0_imm  = im; bus.req0_cin = ci;
        end
    endtask

    task automatic wait_grant(input string name, input int p, output logic ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!port_ready(p) && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = port_ready(p);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s.grant: got no ready expected ready on port %0d", name, p);
        end
    endtask

    // Issue one op with resp_ready high; called #1 after a rising edge.
    task automatic run_op(input string name, input int p, input logic [31:0] d,
                          input logic [7:0] a, input logic [1:0] t, input logic im,
                          input logic ci, input logic [31:0] er, input logic ec,
                          input int elat);
        logic ok;
        int lat;
        set_port(p, 1'b1, d, a, t, im, ci);
        wait_grant(name, p, ok);
        @(posedge clk);
        #1;
        set_port(p, 1'b0, d, a, t, im, ci);
        if (!ok) return;
        lat = 1;
        while (!bus.resp_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("%s.lat", name), 32'(lat), 32'(elat));
        chk($sformatf("%s.data", name), bus.resp_data, er);
        chk($sformatf("%s.carry", name), 32'(bus.resp_carry), 32'(ec));
        chk($sformatf("%s.id", name), 32'(bus.resp_id), 32'(p));
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bnd[8];

    initial begin
        logic [31:0] rr;
        logic        rc;
        int          rl;
        int          got;
        int          cyc;
        int          ids[4];
        logic [31:0] dats[4];
        logic [31:0] held;
        logic        ok;

        bnd[0] = 8'd0;  bnd[1] = 8'd1;  bnd[2] = 8'd31; bnd[3] = 8'd32;
        bnd[4] = 8'd33; bnd[5] = 8'd63; bnd[6] = 8'd64; bnd[7] = 8'd255;

        vecs[0]  = '{0, 32'hF000_0001, 8'd4,   2'd0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 2};
        vecs[1]  = '{1, 32'hFFFF_FFFF, 8'd33,  2'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 10};
        vecs[2]  = '{0, 32'h0000_0001, 8'd32,  2'd0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 9};
        vecs[3]  = '{1, 32'h8000_0000, 8'd200, 2'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 9};
        vecs[4]  = '{0, 32'h8000_0001, 8'd64,  2'd3, 1'b0, 1'b0, 32'h8000_0001, 1'b1, 9};
        vecs[5]  = '{1, 32'h0000_0003, 8'd0,   2'd3, 1'b1, 1'b1, 32'h8000_0001, 1'b1, 1};
        vecs[6]  = '{0, 32'h0000_0005, 8'd0,   2'd1, 1'b0, 1'b1, 32'h0000_0005, 1'b1, 1};
        vecs[7]  = '{1, 32'h8000_0000, 8'd0,   2'd1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 9};
        vecs[8]  = '{0, 32'h7FFF_FFFF, 8'd0,   2'd2, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 9};
        vecs[9]  = '{1, 32'h1234_5678, 8'd0,   2'd0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1};
        vecs[10] = '{0, 32'h0000_000F, 8'd4,   2'd3, 1'b1, 1'b0, 32'hF000_0000, 1'b1, 2};
        vecs[11] = '{1, 32'h0000_0003, 8'd1,   2'd1, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 2};
        vecs[12] = '{0, 32'hFFFF_FFFF, 8'd33,  2'd0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 10};

        reset = 1'b1;
        set_port(0, 1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
        set_port(1, 1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(bus.resp_valid), 32'h0);
        chk("rst.data", bus.resp_data, 32'h0);
        chk("rst.carry", 32'(bus.resp_carry), 32'h0);
        chk("rst.id", 32'(bus.resp_id), 32'h0);
        chk("rst.ready", {30'b0, bus.req1_ready, bus.req0_ready}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].port, vecs[i].d, vecs[i].a, vecs[i].t,
                   vecs[i].im, vecs[i].ci, vecs[i].er, vecs[i].ec, vecs[i].lat);
        end

        // Alternation under continuous contention, from a fresh reset.
        reset = 1'b1;
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        set_port(0, 1'b1, 32'h0000_00A0, 8'd0, 2'd0, 1'b1, 1'b0);
        set_port(1, 1'b1, 32'h0000_00B1, 8'd0, 2'd0, 1'b1, 1'b0);
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.resp_valid && bus.resp_ready) begin
                ids[got]  = int'(bus.resp_id);
                dats[got] = bus.resp_data;
                got++;
            end
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("alt.count", 32'(got), 32'd4);
        for (int i = 0; i < got; i++) begin
            chk($sformatf("alt%0d.id", i), 32'(ids[i]), 32'(i % 2));
            chk($sformatf("alt%0d.data", i), dats[i], (i % 2 == 0) ? 32'hA0 : 32'hB1);
        end
        @(posedge clk);
        #1;

        // Backpressure: response held, no grants while stalled.
        bus.resp_ready = 1'b0;
        set_port(1, 1'b1, 32'h0000_0077, 8'd0, 2'd0, 1'b1, 1'b0);
        set_port(0, 1'b1, 32'hF000_0001, 8'd4, 2'd0, 1'b0, 1'b0);
        wait_grant("bp", 0, ok);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        cyc = 0;
        while (!bus.resp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        held = bus.resp_data;
        chk("bp.data", held, 32'h0000_0010);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d.valid", i), 32'(bus.resp_valid), 32'h1);
            chk($sformatf("bp%0d.hold", i), bus.resp_data, held);
            chk($sformatf("bp%0d.carry", i), 32'(bus.resp_carry), 32'h1);
            chk($sformatf("bp%0d.ready", i), {30'b0, bus.req1_ready, bus.req0_ready}, 32'h0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b0;
        chk("bp.release", 32'(bus.resp_valid), 32'h0);
        @(posedge clk);
        #1;

        // Reset in the middle of a long shift drops the operation.
        set_port(1, 1'b1, 32'hFFFF_FFFF, 8'd33, 2'd1, 1'b0, 1'b0);
        wait_grant("rs", 1, ok);
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rs.valid_now", 32'(bus.resp_valid), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("rs.dropped", 32'(bus.resp_valid), 32'h0);
        set_port(0, 1'b1, 32'h0000_0001, 8'd1, 2'd0, 1'b0, 1'b0);
        set_port(1, 1'b1, 32'h0000_0002, 8'd1, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rs.first_grant", {30'b0, bus.req1_ready, bus.req0_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        cyc = 0;
        while (!bus.resp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rs.after_data", bus.resp_data, 32'h0000_0002);
        @(posedge clk);
        #1;

        for (int i = 0; i < 80; i++) begin
            int          p;
            int          sel;
            logic [31:0] d;
            logic [7:0]  a;
            logic [1:0]  t;
            logic        im;
            logic        ci;
            p   = int'($urandom_range(0, 1));
            d   = $urandom;
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      a = 8'($urandom_range(0, 40));
            else if (sel == 1) a = 8'($urandom_range(0, 255));
            else               a = bnd[$urandom_range(0, 7)];
            t  = 2'($urandom_range(0, 3));
            im = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            if (im) a = a & 8'h1F;
            ref_op(d, a, t, im, ci, rr, rc, rl);
            run_op($sformatf("rnd%0d", i), p, d, a, t, im, ci, rr, rc, rl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
